// File: rtl/reg_bus_sequencer_pkg.sv
// Shared CPU register-bus definitions: sequencer state encoding, register index
// width and the register names used by the microcode.
package reg_bus_sequencer_pkg;

  localparam int REG_W = 3;
  localparam int CNT_W = 4;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_A   = 3'd0;
  localparam reg_idx_t REG_B   = 3'd1;
  localparam reg_idx_t REG_C   = 3'd2;
  localparam reg_idx_t REG_D   = 3'd3;
  localparam reg_idx_t REG_E   = 3'd4;
  localparam reg_idx_t REG_H   = 3'd5;
  localparam reg_idx_t REG_L   = 3'd6;
  localparam reg_idx_t REG_OUT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    seq_state_t       state;
    logic [2:0]       rr_ptr;
    logic [CNT_W-1:0] cnt;
  } seq_dbg_t;

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Requester-side bundle of the register bus sequencer: requests in, grants,
// completion pulses and register-file decoder controls out.
interface reg_bus_sequencer_if #(parameter int NREQ = 4);
  import reg_bus_sequencer_pkg::*;

  // Handshake: req[i] is a level held until done[i] pulses (or the requester
  // drops it while DRIVE to abort); src/dst of i must be stable while req[i]
  // is high; grant[i] marks ownership and done[i] is a single-cycle completion.
  logic                  halt;
  logic [NREQ-1:0]       req;
  logic [REG_W*NREQ-1:0] src;
  logic [REG_W*NREQ-1:0] dst;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  reg_idx_t              oe_sel;
  logic                  oe_en;
  reg_idx_t              ld_sel;
  logic                  ld_en;
  logic                  busy;

  modport master (
    output halt, req, src, dst,
    input  grant, done, oe_sel, oe_en, ld_sel, ld_en, busy
  );

  modport slave (
    input  halt, req, src, dst,
    output grant, done, oe_sel, oe_en, ld_sel, ld_en, busy
  );

endinterface

// File: rtl/reg_bus_sequencer_rr_arbiter.sv
// Combinational rotating-priority arbiter: first request at or above ptr wins,
// scanning upward with wrap.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] cand;

  // Walk offsets from farthest to nearest so the closest hit to ptr is the
  // last assignment and therefore wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    if (en) begin
      for (int off = NREQ - 1; off >= 0; off--) begin
        cand = PW'((int'(ptr) + off) % NREQ);
        if (req[cand]) begin
          grant       = '0;
          grant[cand] = 1'b1;
          idx         = cand;
        end
      end
    end
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Round-robin sequencer serialising register-to-register transfers over the
// shared CPU data bus and driving the output-enable and load decoders.
module reg_bus_sequencer
  import reg_bus_sequencer_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_bus_sequencer_if.slave   bus,
  output seq_dbg_t             dbg
);

  localparam int PW = $clog2(NREQ);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d, win_q, win_d;
  reg_idx_t         src_q, src_d, dst_q, dst_d;

  logic [NREQ-1:0]  arb_grant;
  logic [PW-1:0]    arb_idx;
  reg_idx_t         req_src, req_dst;

  logic [NREQ-1:0]  grant_d, grant_q, done_d, done_q;
  logic             oe_en_d, oe_en_q, ld_en_d, ld_en_q, busy_d, busy_q;
  reg_idx_t         oe_sel_d, oe_sel_q, ld_sel_d, ld_sel_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .en    (state_q == ST_IDLE && !bus.halt),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    req_src = REG_A;
    req_dst = REG_A;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        req_src = bus.src[REG_W*i +: REG_W];
        req_dst = bus.dst[REG_W*i +: REG_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      src_q   <= REG_A;
      dst_q   <= REG_A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  // A src==dst transfer skips the bus: it enters DONE with cnt=1 so the grant
  // is shown for one cycle before the done pulse, reusing the settle counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          win_d = arb_idx;
          src_d = req_src;
          dst_d = req_dst;
          ptr_d = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
          if (req_src == req_dst) begin
            state_d = ST_DONE;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ST_DRIVE;
            cnt_d   = CNT_W'(SETTLE - 1);
          end
        end
      end
      ST_DRIVE: begin
        if (!bus.req[win_q]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_LATCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LATCH: state_d = ST_DONE;
      ST_DONE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state they describe and never follow inputs combinationally.
  always_comb begin
    grant_d  = '0;
    done_d   = '0;
    oe_en_d  = 1'b0;
    ld_en_d  = 1'b0;
    oe_sel_d = REG_A;
    ld_sel_d = REG_A;
    busy_d   = (state_d != ST_IDLE);
    if (busy_d) begin
      oe_sel_d = src_d;
      ld_sel_d = dst_d;
    end
    case (state_d)
      ST_DRIVE: begin
        grant_d[win_d] = 1'b1;
        oe_en_d        = 1'b1;
      end
      ST_LATCH: begin
        grant_d[win_d] = 1'b1;
        oe_en_d        = 1'b1;
        ld_en_d        = 1'b1;
      end
      ST_DONE: begin
        if (cnt_d != '0) grant_d[win_d] = 1'b1;
        else             done_d[win_d]  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      done_q   <= '0;
      oe_en_q  <= 1'b0;
      ld_en_q  <= 1'b0;
      oe_sel_q <= REG_A;
      ld_sel_q <= REG_A;
      busy_q   <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      done_q   <= done_d;
      oe_en_q  <= oe_en_d;
      ld_en_q  <= ld_en_d;
      oe_sel_q <= oe_sel_d;
      ld_sel_q <= ld_sel_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.oe_en  = oe_en_q;
  assign bus.ld_en  = ld_en_q;
  assign bus.oe_sel = oe_sel_q;
  assign bus.ld_sel = ld_sel_q;
  assign bus.busy   = busy_q;

  assign dbg.state  = state_q;
  assign dbg.rr_ptr = 3'(ptr_q);
  assign dbg.cnt    = cnt_q;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Directed bench for reg_bus_sequencer: one DUT with SETTLE=1 and one with
// SETTLE=3, sharing clock and reset.
module tb_reg_bus_sequencer;
  import reg_bus_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  reg_bus_sequencer_if #(.NREQ(4)) bus1 ();
  reg_bus_sequencer_if #(.NREQ(4)) bus3 ();
  seq_dbg_t dbg1, dbg3;

  reg_bus_sequencer #(.NREQ(4), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg(dbg1)
  );
  reg_bus_sequencer #(.NREQ(4), .SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .dbg(dbg3)
  );

  // {grant, done, oe_en, oe_sel, ld_en, ld_sel, busy}
  wire [16:0] obs1 = {bus1.grant, bus1.done, bus1.oe_en, bus1.oe_sel,
                      bus1.ld_en, bus1.ld_sel, bus1.busy};
  wire [16:0] obs3 = {bus3.grant, bus3.done, bus3.oe_en, bus3.oe_sel,
                      bus3.ld_en, bus3.ld_sel, bus3.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_path1(input int i, input logic [2:0] s, input logic [2:0] d);
    bus1.src[3*i +: 3] = s;
    bus1.dst[3*i +: 3] = d;
  endtask

  task automatic set_path3(input int i, input logic [2:0] s, input logic [2:0] d);
    bus3.src[3*i +: 3] = s;
    bus3.dst[3*i +: 3] = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (obs1 !== 17'd0) begin
      fails++; $display("FAIL reset_out1: got %h exp %h", obs1, 17'd0);
    end
    tests++;
    if (obs3 !== 17'd0) begin
      fails++; $display("FAIL reset_out3: got %h exp %h", obs3, 17'd0);
    end
    tests++;
    if (dbg1 !== 9'd0) begin
      fails++; $display("FAIL reset_dbg1: got %h exp %h", dbg1, 9'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (obs1 !== 17'd0) begin
      fails++; $display("FAIL reset_idle1: got %h exp %h", obs1, 17'd0);
    end
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] oh;
    logic [7:0] exp_gd;
    for (int i = 0; i < 4; i++) set_path1(i, 3'(i), 3'(i + 4));
    bus1.req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      oh = 4'b0001 << order[(c - 1) / 4];
      case ((c - 1) % 4)
        0, 1:    exp_gd = {oh, 4'b0000};
        2:       exp_gd = {4'b0000, oh};
        default: exp_gd = 8'h00;
      endcase
      tests++;
      if ({bus1.grant, bus1.done} !== exp_gd) begin
        fails++;
        $display("FAIL rr_c%0d: got grant/done %h exp %h", c, {bus1.grant, bus1.done}, exp_gd);
      end
      if (c == 20) bus1.req = 4'b0000;
    end
  endtask

  task automatic test_single;
    logic [16:0] exp_v[4];
    exp_v[0] = {4'b0001, 4'b0000, 1'b1, 3'd2, 1'b0, 3'd5, 1'b1};
    exp_v[1] = {4'b0001, 4'b0000, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1};
    exp_v[2] = {4'b0000, 4'b0001, 1'b0, 3'd2, 1'b0, 3'd5, 1'b1};
    exp_v[3] = 17'd0;
    set_path1(0, 3'd2, 3'd5);
    bus1.req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests++;
      if (obs1 !== exp_v[c-1]) begin
        fails++; $display("FAIL single_c%0d: got %h exp %h", c, obs1, exp_v[c-1]);
      end
      if (c == 3) bus1.req = 4'b0000;
    end
  endtask

  task automatic test_same_reg;
    logic [16:0] exp_v[3];
    exp_v[0] = {4'b0100, 4'b0000, 1'b0, 3'd4, 1'b0, 3'd4, 1'b1};
    exp_v[1] = {4'b0000, 4'b0100, 1'b0, 3'd4, 1'b0, 3'd4, 1'b1};
    exp_v[2] = 17'd0;
    set_path1(2, 3'd4, 3'd4);
    bus1.req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests++;
      if (obs1 !== exp_v[c-1]) begin
        fails++; $display("FAIL same_reg_c%0d: got %h exp %h", c, obs1, exp_v[c-1]);
      end
      if (c == 2) bus1.req = 4'b0000;
    end
  endtask

  task automatic test_halt;
    logic [16:0] exp_v[5];
    exp_v[0] = {4'b0010, 4'b0000, 1'b1, 3'd1, 1'b0, 3'd6, 1'b1};
    exp_v[1] = {4'b0010, 4'b0000, 1'b1, 3'd1, 1'b1, 3'd6, 1'b1};
    exp_v[2] = {4'b0000, 4'b0010, 1'b0, 3'd1, 1'b0, 3'd6, 1'b1};
    exp_v[3] = 17'd0;
    exp_v[4] = 17'd0;
    set_path1(1, 3'd1, 3'd6);
    bus1.halt = 1'b1;
    bus1.req  = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests++;
      if (obs1 !== 17'd0) begin
        fails++; $display("FAIL halt_hold_c%0d: got %h exp %h", c, obs1, 17'd0);
      end
    end
    bus1.halt = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      tests++;
      if (obs1 !== exp_v[c-1]) begin
        fails++; $display("FAIL halt_xfer_c%0d: got %h exp %h", c, obs1, exp_v[c-1]);
      end
      if (c == 1) bus1.halt = 1'b1;
      if (c == 3) bus1.req = 4'b0000;
      if (c == 4) bus1.req = 4'b0010;
    end
    bus1.req  = 4'b0000;
    bus1.halt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    logic [16:0] exp_v[4];
    exp_v[0] = {4'b0010, 4'b0000, 1'b1, 3'd3, 1'b0, 3'd7, 1'b1};
    exp_v[1] = exp_v[0];
    exp_v[2] = 17'd0;
    exp_v[3] = 17'd0;
    set_path3(1, 3'd3, 3'd7);
    bus3.req = 4'b0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests++;
      if (obs3 !== exp_v[c-1]) begin
        fails++; $display("FAIL abort_c%0d: got %h exp %h", c, obs3, exp_v[c-1]);
      end
      if (c == 2) bus3.req = 4'b0000;
      if (c == 3) begin
        tests++;
        if (dbg3.state !== ST_IDLE || dbg3.rr_ptr !== 3'd2) begin
          fails++;
          $display("FAIL abort_dbg: got state %0d ptr %0d exp state 0 ptr 2", dbg3.state, dbg3.rr_ptr);
        end
      end
    end
  endtask

  task automatic test_settle3;
    logic [16:0] exp_v[6];
    exp_v[0] = {4'b0100, 4'b0000, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1};
    exp_v[1] = exp_v[0];
    exp_v[2] = exp_v[0];
    exp_v[3] = {4'b0100, 4'b0000, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1};
    exp_v[4] = {4'b0000, 4'b0100, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1};
    exp_v[5] = 17'd0;
    set_path3(2, 3'd0, 3'd1);
    bus3.req = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      tests++;
      if (obs3 !== exp_v[c-1]) begin
        fails++; $display("FAIL settle3_c%0d: got %h exp %h", c, obs3, exp_v[c-1]);
      end
      if (c == 5) bus3.req = 4'b0000;
    end
  endtask

  task automatic test_reset_mid;
    logic [16:0] exp_latch, exp_grant3;
    exp_latch  = {4'b0001, 4'b0000, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1};
    exp_grant3 = {4'b1000, 4'b0000, 1'b1, 3'd5, 1'b0, 3'd6, 1'b1};
    set_path1(0, 3'd1, 3'd2);
    set_path1(3, 3'd5, 3'd6);
    bus1.req = 4'b0001;
    repeat (2) @(negedge clk);
    tests++;
    if (obs1 !== exp_latch) begin
      fails++; $display("FAIL rstmid_latch: got %h exp %h", obs1, exp_latch);
    end
    bus1.req = 4'b1000;
    rst_n    = 1'b0;
    #1;
    tests++;
    if (obs1 !== 17'd0) begin
      fails++; $display("FAIL rstmid_async: got %h exp %h", obs1, 17'd0);
    end
    tests++;
    if (dbg1 !== 9'd0) begin
      fails++; $display("FAIL rstmid_dbg: got %h exp %h", dbg1, 9'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (obs1 !== exp_grant3) begin
      fails++; $display("FAIL rstmid_regrant: got %h exp %h", obs1, exp_grant3);
    end
    bus1.req = 4'b0000;
    repeat (3) @(negedge clk);
    tests++;
    if (obs1 !== 17'd0) begin
      fails++; $display("FAIL rstmid_drain: got %h exp %h", obs1, 17'd0);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    bus1.halt = 1'b0;
    bus1.req  = '0;
    bus1.src  = '0;
    bus1.dst  = '0;
    bus3.halt = 1'b0;
    bus3.req  = '0;
    bus3.src  = '0;
    bus3.dst  = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_same_reg();
    test_halt();
    test_abort();
    test_settle3();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
